fpu_cmp_seq: RTL and testbench

//  Sequencer for the FPU compare path: runs FCOM/FCOMP/FCOMPP/FUCOM*/FTST.

---
 rtl/fpu_cmp_seq_pkg.sv | 48 ++++
 rtl/fpu_cmp_seq_if.sv | 40 ++++
 rtl/fpu_cmp_seq_cmp.sv | 38 +++
 rtl/fpu_cmp_seq.sv | 204 ++++++++++++++++++++
 tb/tb_fpu_cmp_seq.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_cmp_seq_pkg.sv
// Shared FPU definitions for the compare sequencer: op encodings,
// condition-code patterns, fp64 field constants and sequencer types.
package fpu_pkg;

    localparam logic [2:0] FPU_CMP_FCOM   = 3'd0;
    localparam logic [2:0] FPU_CMP_FCOMP  = 3'd1;
    localparam logic [2:0] FPU_CMP_FCOMPP = 3'd2;
    localparam logic [2:0] FPU_CMP_FUCOM  = 3'd3;
    localparam logic [2:0] FPU_CMP_FUCOMP = 3'd4;
    localparam logic [2:0] FPU_CMP_FUCOMPP = 3'd5;
    localparam logic [2:0] FPU_CMP_FTST   = 3'd6;

    // {C3,C2,C1,C0}
    localparam logic [3:0] CC_GT = 4'b0000;
    localparam logic [3:0] CC_LT = 4'b0001;
    localparam logic [3:0] CC_EQ = 4'b1000;
    localparam logic [3:0] CC_UN = 4'b1101;

    localparam logic [10:0] FP64_EXP_MAX = 11'h7FF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_A,
        ST_RD_B,
        ST_CMP,
        ST_WB
    } cmp_state_e;

    typedef struct packed {
        logic sign;
        logic is_nan;
        logic is_snan;
        logic is_inf;
    } fp64_class_t;

    // Number of stack pops an op requests on completion.
    function automatic logic [1:0] pop_count(input logic [2:0] op);
        logic [1:0] n;
        n = 2'd0;
        if (op == FPU_CMP_FCOMP || op == FPU_CMP_FUCOMP) begin
            n = 2'd1;
        end else if (op == FPU_CMP_FCOMPP || op == FPU_CMP_FUCOMPP) begin
            n = 2'd2;
        end
        return n;
    endfunction

endpackage

// File: rtl/fpu_cmp_seq_if.sv
// Bundle between the microcode dispatcher / register stack and the
// compare sequencer. The sequencer takes the slave side.
interface fpu_cmp_seq_if;

    logic        start;
    logic [2:0]  op;
    logic        src_mem;
    logic [2:0]  sti;
    logic [2:0]  top;
    logic [63:0] mem_data;
    logic        flush;

    logic        rd_en;
    logic [2:0]  rd_addr;
    logic [63:0] rd_data;
    logic        rd_empty;

    logic        busy;
    logic        done;
    logic        cc_we;
    logic [3:0]  cc;
    logic [1:0]  pop_cnt;
    logic        ie;
    logic        sf;

    modport master (
        output start, op, src_mem, sti, top, mem_data, flush,
        output rd_data, rd_empty,
        input  rd_en, rd_addr,
        input  busy, done, cc_we, cc, pop_cnt, ie, sf
    );

    modport slave (
        input  start, op, src_mem, sti, top, mem_data, flush,
        input  rd_data, rd_empty,
        output rd_en, rd_addr,
        output busy, done, cc_we, cc, pop_cnt, ie, sf
    );

endinterface

// File: rtl/fpu_cmp_seq_cmp.sv
// Combinational fp64 magnitude comparator. Denormals are treated as zero
// and +0/-0 compare equal; NaN/Inf are not special-cased here, the
// sequencer resolves those before trusting this result.
module fp64_cmp (
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic        lt,
    output logic        eq,
    output logic        gt
);

    logic        zero_a;
    logic        zero_b;
    logic        sign_a;
    logic        sign_b;
    logic [62:0] mag_a;
    logic [62:0] mag_b;

    // Flush zero-exponent values to +0, then do a sign-magnitude compare.
    always_comb begin
        zero_a = (a[62:52] == 11'd0);
        zero_b = (b[62:52] == 11'd0);
        sign_a = zero_a ? 1'b0 : a[63];
        sign_b = zero_b ? 1'b0 : b[63];
        mag_a  = zero_a ? 63'd0 : a[62:0];
        mag_b  = zero_b ? 63'd0 : b[62:0];
        eq     = (sign_a == sign_b) && (mag_a == mag_b);
        if (sign_a != sign_b) begin
            lt = sign_a;
        end else if (!sign_a) begin
            lt = (mag_a < mag_b);
        end else begin
            lt = (mag_a > mag_b);
        end
        gt = !lt && !eq;
    end

endmodule

// File: rtl/fpu_cmp_seq.sv
// FPU compare sequencer: reads ST(0) and the second operand, classifies
// NaN/Inf/empty cases, uses fp64_cmp for ordinary values and reports
// C3..C0, invalid/stack-fault flags and the pop count in one WB cycle.
module fpu_cmp_seq
    import fpu_pkg::*;
#(
    parameter bit FIXED_LAT = 1'b1
) (
    input logic         clk,
    input logic         rst_n,
    fpu_cmp_seq_if.slave bus
);

    cmp_state_e  state;
    cmp_state_e  next_state;

    logic [2:0]  op_q;
    logic        src_mem_q;
    logic [2:0]  sti_q;
    logic [2:0]  top_q;
    logic [63:0] a_q;
    logic [63:0] b_q;
    logic        empty_a_q;
    logic [3:0]  cc_q;
    logic        ie_q;
    logic        sf_q;

    logic        accept;
    logic        b_is_reg;
    logic        skip_rd_b;
    logic        unordered_op;
    logic        wb_valid;

    logic [63:0] a_cur;
    logic [63:0] b_cur;
    logic        empty_a_cur;
    logic        empty_b_cur;
    fp64_class_t cls_a;
    fp64_class_t cls_b;
    logic        cmp_lt;
    logic        cmp_eq;
    logic        cmp_gt;
    logic [3:0]  res_cc;
    logic        res_ie;
    logic        res_sf;

    function automatic fp64_class_t classify(input logic [63:0] v);
        fp64_class_t c;
        logic        exp_max;
        logic        frac_zero;
        exp_max   = (v[62:52] == FP64_EXP_MAX);
        frac_zero = (v[51:0] == 52'd0);
        c.sign    = v[63];
        c.is_nan  = exp_max && !frac_zero;
        c.is_snan = c.is_nan && !v[51];
        c.is_inf  = exp_max && frac_zero;
        return c;
    endfunction

    assign accept       = (state == ST_IDLE) && bus.start && !bus.flush;
    assign b_is_reg     = !src_mem_q && (op_q != FPU_CMP_FTST);
    assign skip_rd_b    = !FIXED_LAT && !b_is_reg;
    assign unordered_op = (op_q == FPU_CMP_FUCOM) || (op_q == FPU_CMP_FUCOMP) ||
                          (op_q == FPU_CMP_FUCOMPP);

    // In CMP, A comes straight off the read port when RD_B was skipped, and
    // a register B is still on the read port; otherwise the registers hold them.
    assign a_cur       = skip_rd_b ? bus.rd_data : a_q;
    assign empty_a_cur = skip_rd_b ? bus.rd_empty : empty_a_q;
    assign b_cur       = b_is_reg ? bus.rd_data : b_q;
    assign empty_b_cur = b_is_reg && bus.rd_empty;

    assign cls_a = classify(a_cur);
    assign cls_b = classify(b_cur);

    fp64_cmp u_cmp (
        .a  (a_cur),
        .b  (b_cur),
        .lt (cmp_lt),
        .eq (cmp_eq),
        .gt (cmp_gt)
    );

    // Result selection: empty tags beat NaNs, NaNs beat Infs, Infs beat the comparator.
    always_comb begin
        res_cc = CC_EQ;
        res_ie = 1'b0;
        res_sf = 1'b0;
        if (empty_a_cur || empty_b_cur) begin
            res_cc = CC_UN;
            res_ie = 1'b1;
            res_sf = 1'b1;
        end else if (cls_a.is_nan || cls_b.is_nan) begin
            res_cc = CC_UN;
            res_ie = unordered_op ? (cls_a.is_snan || cls_b.is_snan) : 1'b1;
        end else if (cls_a.is_inf && cls_b.is_inf) begin
            if (cls_a.sign == cls_b.sign) begin
                res_cc = CC_EQ;
            end else begin
                res_cc = cls_a.sign ? CC_LT : CC_GT;
            end
        end else if (cls_a.is_inf) begin
            res_cc = cls_a.sign ? CC_LT : CC_GT;
        end else if (cls_b.is_inf) begin
            res_cc = cls_b.sign ? CC_GT : CC_LT;
        end else if (cmp_eq) begin
            res_cc = CC_EQ;
        end else if (cmp_lt) begin
            res_cc = CC_LT;
        end else if (cmp_gt) begin
            res_cc = CC_GT;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and output decode; flush overrides everything, including a WB in flight.
    always_comb begin
        next_state   = state;
        bus.rd_en    = 1'b0;
        bus.rd_addr  = 3'd0;
        bus.busy     = (state != ST_IDLE);
        wb_valid     = (state == ST_WB) && !bus.flush;
        bus.done     = wb_valid;
        bus.cc_we    = wb_valid;
        bus.cc       = wb_valid ? cc_q : 4'd0;
        bus.pop_cnt  = wb_valid ? pop_count(op_q) : 2'd0;
        bus.ie       = wb_valid && ie_q;
        bus.sf       = wb_valid && sf_q;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    next_state = ST_RD_A;
                end
            end
            ST_RD_A: begin
                bus.rd_en   = 1'b1;
                bus.rd_addr = top_q;
                next_state  = skip_rd_b ? ST_CMP : ST_RD_B;
            end
            ST_RD_B: begin
                bus.rd_en   = b_is_reg;
                bus.rd_addr = b_is_reg ? (top_q + sti_q) : 3'd0;
                next_state  = ST_CMP;
            end
            ST_CMP: begin
                next_state = ST_WB;
            end
            ST_WB: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
        if (bus.flush) begin
            next_state = ST_IDLE;
        end
    end

    // Operand latching at accept, A capture in RD_B, result capture in CMP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= 3'd0;
            src_mem_q <= 1'b0;
            sti_q     <= 3'd0;
            top_q     <= 3'd0;
            a_q       <= 64'd0;
            b_q       <= 64'd0;
            empty_a_q <= 1'b0;
            cc_q      <= 4'd0;
            ie_q      <= 1'b0;
            sf_q      <= 1'b0;
        end else begin
            if (accept) begin
                op_q      <= bus.op;
                src_mem_q <= bus.src_mem;
                sti_q     <= bus.sti;
                top_q     <= bus.top;
                b_q       <= (bus.op == FPU_CMP_FTST) ? 64'd0 : bus.mem_data;
            end
            if (state == ST_RD_B) begin
                a_q       <= bus.rd_data;
                empty_a_q <= bus.rd_empty;
            end
            if (state == ST_CMP) begin
                a_q       <= a_cur;
                b_q       <= b_cur;
                empty_a_q <= empty_a_cur;
                cc_q      <= res_cc;
                ie_q      <= res_ie;
                sf_q      <= res_sf;
            end
        end
    end

endmodule

// File: tb/tb_fpu_cmp_seq.sv
// Directed bench for fpu_cmp_seq: a small register-stack model answers the
// read port, expected results go into a scoreboard queue at start and are
// popped and compared when done is seen.
module tb_fpu_cmp_seq;
    import fpu_pkg::*;

    typedef struct {
        logic [3:0] cc;
        logic [1:0] pop;
        logic       ie;
        logic       sf;
        int         lat;
        string      tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    int errors = 0;
    int checks = 0;

    logic [63:0] regs [8];
    logic        empty_tag [8];
    logic        pend_rd = 1'b0;
    logic [2:0]  pend_addr = 3'd0;
    logic [2:0]  addr_log [$];
    exp_t        sb [$];

    always #5 clk = ~clk;

    fpu_cmp_seq_if bus ();

    fpu_cmp_seq #(.FIXED_LAT(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Stack model: note the strobe mid-cycle, return data just after the next edge.
    always @(negedge clk) begin
        pend_rd = bus.rd_en;
        pend_addr = bus.rd_addr;
        if (bus.rd_en) addr_log.push_back(bus.rd_addr);
    end

    always @(posedge clk) begin
        #1;
        if (pend_rd) begin
            bus.rd_data = regs[pend_addr];
            bus.rd_empty = empty_tag[pend_addr];
        end else begin
            bus.rd_data = 64'hDEAD_BEEF_0BAD_F00D;
            bus.rd_empty = 1'b0;
        end
    end

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [2:0] op, input logic sm, input logic [2:0] sti,
                                  input logic [2:0] tp, input logic [63:0] mem);
        @(negedge clk);
        addr_log.delete();
        bus.start = 1'b1;
        bus.op = op;
        bus.src_mem = sm;
        bus.sti = sti;
        bus.top = tp;
        bus.mem_data = mem;
    endtask

    task automatic push_exp(input string tag, input logic [3:0] ecc, input logic [1:0] epop,
                            input logic eie, input logic esf);
        exp_t e;
        e.cc = ecc;
        e.pop = epop;
        e.ie = eie;
        e.sf = esf;
        e.lat = 4;
        e.tag = tag;
        sb.push_back(e);
    endtask

    // Waits (bounded) for done, then pops the scoreboard and compares.
    task automatic wait_result(input string tag, input int start_lat);
        exp_t e;
        int   lat;
        bit   seen;
        lat = start_lat;
        seen = 1'b0;
        while (!seen && lat < 20) begin
            if (bus.done) seen = 1'b1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        check_output({tag, "_done_seen"}, 64'(seen), 64'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            if (seen) begin
                check_output({e.tag, "_cc"}, 64'(bus.cc), 64'(e.cc));
                check_output({e.tag, "_pop"}, 64'(bus.pop_cnt), 64'(e.pop));
                check_output({e.tag, "_ie"}, 64'(bus.ie), 64'(e.ie));
                check_output({e.tag, "_sf"}, 64'(bus.sf), 64'(e.sf));
                check_output({e.tag, "_cc_we"}, 64'(bus.cc_we), 64'd1);
                check_output({e.tag, "_latency"}, 64'(lat), 64'(e.lat));
            end
        end
        @(negedge clk);
        check_output({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic sm, input logic [2:0] sti,
                          input logic [2:0] tp, input logic [63:0] mem, input logic [3:0] ecc,
                          input logic [1:0] epop, input logic eie, input logic esf);
        apply_stimulus(op, sm, sti, tp, mem);
        push_exp(tag, ecc, epop, eie, esf);
        @(negedge clk);
        bus.start = 1'b0;
        wait_result(tag, 1);
    endtask

    initial begin
        bit any_done;
        for (int i = 0; i < 8; i++) begin
            regs[i] = 64'd0;
            empty_tag[i] = 1'b0;
        end
        bus.start = 1'b0;
        bus.op = 3'd0;
        bus.src_mem = 1'b0;
        bus.sti = 3'd0;
        bus.top = 3'd0;
        bus.mem_data = 64'd0;
        bus.flush = 1'b0;

        $display("[TB] reset");
        #12;
        check_output("reset_outputs",
                     64'({bus.busy, bus.done, bus.cc_we, bus.rd_en, bus.rd_addr, bus.cc, bus.pop_cnt, bus.ie, bus.sf}),
                     64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_output("idle_busy", 64'(bus.busy), 64'd0);

        $display("[TB] FCOM 1.0 vs 2.0");
        regs[0] = 64'h3FF0_0000_0000_0000;
        regs[1] = 64'h4000_0000_0000_0000;
        run_op("fcom_lt", FPU_CMP_FCOM, 1'b0, 3'd1, 3'd0, 64'd0, CC_LT, 2'd0, 1'b0, 1'b0);
        check_output("fcom_lt_reads", 64'(addr_log.size()), 64'd2);
        if (addr_log.size() == 2) check_output("fcom_lt_addr_a", 64'(addr_log[0]), 64'd0);

        $display("[TB] FCOMPP -0 vs +0 with TOP wrap");
        regs[7] = 64'h8000_0000_0000_0000;
        regs[0] = 64'h0000_0000_0000_0000;
        run_op("fcompp_zero", FPU_CMP_FCOMPP, 1'b0, 3'd1, 3'd7, 64'd0, CC_EQ, 2'd2, 1'b0, 1'b0);
        check_output("fcompp_reads", 64'(addr_log.size()), 64'd2);
        if (addr_log.size() == 2) begin
            check_output("fcompp_addr_a", 64'(addr_log[0]), 64'd7);
            check_output("fcompp_addr_b_wrap", 64'(addr_log[1]), 64'd0);
        end

        $display("[TB] NaN handling");
        regs[2] = 64'h3FF0_0000_0000_0000;
        run_op("fucom_qnan", FPU_CMP_FUCOM, 1'b1, 3'd0, 3'd2, 64'h7FF8_0000_0000_0000, CC_UN, 2'd0, 1'b0, 1'b0);
        check_output("fucom_qnan_reads", 64'(addr_log.size()), 64'd1);
        run_op("fcom_qnan", FPU_CMP_FCOM, 1'b1, 3'd0, 3'd2, 64'h7FF8_0000_0000_0000, CC_UN, 2'd0, 1'b1, 1'b0);
        run_op("fucom_snan", FPU_CMP_FUCOM, 1'b1, 3'd0, 3'd2, 64'h7FF0_0000_0000_0001, CC_UN, 2'd0, 1'b1, 1'b0);

        $display("[TB] Inf handling");
        regs[3] = 64'hFFF0_0000_0000_0000;
        run_op("ftst_neginf", FPU_CMP_FTST, 1'b0, 3'd1, 3'd3, 64'h4000_0000_0000_0000, CC_LT, 2'd0, 1'b0, 1'b0);
        check_output("ftst_reads", 64'(addr_log.size()), 64'd1);
        regs[3] = 64'h7FF0_0000_0000_0000;
        run_op("mem_inf_eq", FPU_CMP_FCOM, 1'b1, 3'd0, 3'd3, 64'h7FF0_0000_0000_0000, CC_EQ, 2'd0, 1'b0, 1'b0);
        regs[4] = 64'h3FF0_0000_0000_0000;
        run_op("inf_gt_reg", FPU_CMP_FCOM, 1'b0, 3'd1, 3'd3, 64'd0, CC_GT, 2'd0, 1'b0, 1'b0);

        $display("[TB] stack fault");
        regs[5] = 64'h3FF0_0000_0000_0000;
        regs[6] = 64'h3FF0_0000_0000_0000;
        empty_tag[5] = 1'b1;
        run_op("fcomp_empty", FPU_CMP_FCOMP, 1'b0, 3'd1, 3'd5, 64'd0, CC_UN, 2'd1, 1'b1, 1'b1);
        empty_tag[5] = 1'b0;

        $display("[TB] ordinary values");
        regs[0] = 64'h4008_0000_0000_0000;
        regs[1] = 64'hC014_0000_0000_0000;
        run_op("fucompp_gt", FPU_CMP_FUCOMPP, 1'b0, 3'd1, 3'd0, 64'd0, CC_GT, 2'd2, 1'b0, 1'b0);
        regs[0] = 64'h0000_0000_0000_0001;
        regs[1] = 64'h0000_0000_0000_0000;
        run_op("denorm_eq", FPU_CMP_FCOM, 1'b0, 3'd1, 3'd0, 64'd0, CC_EQ, 2'd0, 1'b0, 1'b0);
        regs[0] = 64'hC000_0000_0000_0000;
        run_op("neg_lt", FPU_CMP_FUCOMP, 1'b1, 3'd0, 3'd0, 64'hBFF0_0000_0000_0000, CC_LT, 2'd1, 1'b0, 1'b0);

        $display("[TB] flush in CMP");
        regs[0] = 64'h3FF0_0000_0000_0000;
        regs[1] = 64'h4000_0000_0000_0000;
        apply_stimulus(FPU_CMP_FCOMPP, 1'b0, 3'd1, 3'd0, 64'd0);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check_output("flush_busy", 64'(bus.busy), 64'd0);
        any_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (bus.done || bus.cc_we || bus.pop_cnt != 2'd0) any_done = 1'b1;
            @(negedge clk);
        end
        check_output("flush_no_done", 64'(any_done), 64'd0);

        $display("[TB] start while busy");
        apply_stimulus(FPU_CMP_FCOM, 1'b0, 3'd1, 3'd0, 64'd0);
        push_exp("busy_first", CC_LT, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op = FPU_CMP_FCOMPP;
        bus.sti = 3'd0;
        @(negedge clk);
        bus.start = 1'b0;
        wait_result("busy_first", 3);
        any_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bus.done) any_done = 1'b1;
            @(negedge clk);
        end
        check_output("busy_start_ignored", 64'(any_done), 64'd0);

        $display("[TB] async reset in RD_B");
        apply_stimulus(FPU_CMP_FCOM, 1'b0, 3'd1, 3'd0, 64'd0);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_output("rst_mid_outputs",
                     64'({bus.busy, bus.done, bus.cc_we, bus.rd_en, bus.rd_addr, bus.cc, bus.pop_cnt, bus.ie, bus.sf}),
                     64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        any_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bus.done || bus.busy) any_done = 1'b1;
            @(negedge clk);
        end
        check_output("rst_mid_no_activity", 64'(any_done), 64'd0);
        check_output("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
